instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
// - Inverse of the control decoder: packs RV32I fields (class, ALU op, funct3, regs, imm) into 32-bit instruction words.
// - Streams each word, tagged with a sequential byte address, to the instruction-memory write port of the test/loader path.
// - Single-entry registered pipeline with valid/ready on both sides; flags illegal field combinations.
// PARAMETERS
// - ADDR_WIDTH  32      width of out_addr
// - BASE_ADDR   32'h0   address of first word after reset/clear
// - CNT_WIDTH   16      width of instr_count (saturating)
// PORTS
// - clk          in   1            clock, rising edge
// - rst_n        in   1            asynchronous, active-low reset
// - clear        in   1            sync restart: addr<=BASE_ADDR, out_valid<=0, count<=0
// - in_valid     in   1            input fields valid
// - in_ready     out  1            encoder can accept
// - in_class     in   4            0 R,1 I-ALU,2 LOAD,3 STORE,4 BRANCH,5 JAL,6 JALR,7 LUI,8 AUIPC
// - in_alu_op    in   4            ALUControl code: 0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,8 slt,9 sltu
// - in_funct3    in   3            width (LOAD/STORE) or condition (BRANCH)
// - in_rd/in_rs1/in_rs2 in 5 each  register indices
// - in_imm       in   32           byte offset / value; LUI/AUIPC: full upper value
// - out_valid    out  1            encoded word valid
// - out_ready    in   1            consumer accepts
// - out_instr    out  32           encoded instruction
// - out_addr     out  ADDR_WIDTH   byte address of out_instr
// - out_err      out  1            illegal combination for this word
// - instr_count  out  CNT_WIDTH    accepted output transfers, saturates at all-ones
// BEHAVIOUR
// - Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, instr_count=0, addr ptr=BASE_ADDR.
// - in_ready = !clear && (!out_valid || out_ready). Accept = in_valid && in_ready.
// - Latency 1: on accept, out_instr/out_err/out_addr registered next edge; out_valid=1; addr ptr += 4 (wraps mod 2^ADDR_WIDTH).
// - Output held stable while out_valid && !out_ready. Accept+drain same cycle = back-to-back, no bubble.
// - out_valid && out_ready && !accept -> out_valid=0 next edge. Transfer increments instr_count (saturating).
// - clear wins over all events: pending word dropped, not counted; in_ready=0 that cycle.
// - rst_n low mid-transfer: everything returns to reset values immediately.
// - Encoding: standard RV32I field placement; opcodes 33/13/03/23/63/6F/67/37/17 (hex) by class.
// - R: funct3/funct7 from alu_op (sub->000/20, sra->101/20, others funct7=00).
// - I-ALU: sll/srl/sra use imm[4:0] as shamt, funct7 in [31:25]; else imm[11:0].
// - LOAD/JALR: imm[11:0]; JALR funct3=000. STORE: S-split imm[11:0].
// - BRANCH: imm[12:1] B-split; JAL: imm[20:1] J-split; LUI/AUIPC: imm[31:12].
// - Fields not used by a class are encoded as zero (e.g. rs2 for I-type).
// - Illegal (out_err=1, word still encoded from truncated fields): in_class>8; alu_op>9;
//   sub with I-ALU; alu_op not add for LOAD/STORE; LOAD funct3 in {011,110,111};
//   STORE funct3>010; BRANCH funct3 in {010,011}.
// CONFIGURATION
// - IMM_CHECK_EN defined: additionally out_err=1 if imm out of range: I/S/JALR signed 12-bit;
//   shamt>31; B signed 13-bit or imm[0]=1; J signed 21-bit or imm[0]=1; U imm[11:0]!=0.
// - IMM_CHECK_EN undefined: no range checks, imm silently truncated; field checks remain.
// TESTING
// - addi x1,x0,5 (class1,op0,imm 5) -> out_instr 0x00500093, out_addr 0x0, err 0, 1 cycle later.
// - add x3,x1,x2 then sub x3,x1,x2 back-to-back, out_ready=1 -> 0x002081B3 @0x0, 0x402081B3 @0x4, no bubble.
// - beq x1,x2,+8 -> 0x00208463; jal x1,+16 -> 0x010000EF; lui x5,0x12345000 -> 0x123452B7.
// - out_ready=0 for 3 cycles with word pending -> in_ready=0, out_instr stable, count unchanged; then drains, count+1.
// - clear asserted with word pending and in_valid=1 -> out_valid=0, next accepted word at BASE_ADDR, count=0.
// - addi imm=2048: IMM_CHECK_EN -> out_err=1; undefined -> out_err=0, word 0x80000093 (rd=x1). BRANCH funct3=010 -> out_err=1 both builds.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field-in / word-out handshake bundle for instr_encoder.
// slave = encoder side, master = producer of fields and consumer of words.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_class;
  logic [3:0]            in_alu_op;
  logic [2:0]            in_funct3;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_err;

  modport slave (
    input  in_valid, in_class, in_alu_op, in_funct3, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport master (
    output in_valid, in_class, in_alu_op, in_funct3, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I fields into 32-bit words and streams them with sequential byte addresses.
// Define IMM_CHECK_EN to also flag out-of-range immediates on out_err.
module instr_encoder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  instr_encoder_if.slave       bus,
  output logic [CNT_WIDTH-1:0] instr_count
);
`ifdef IMM_CHECK_EN
  localparam bit IMM_CHK = 1'b1;
`else
  localparam bit IMM_CHK = 1'b0;
`endif

  localparam logic [3:0] C_R = 4'd0, C_IALU = 4'd1, C_LOAD = 4'd2, C_STORE = 4'd3, C_BRANCH = 4'd4,
                         C_JAL = 4'd5, C_JALR = 4'd6, C_LUI = 4'd7, C_AUIPC = 4'd8;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4,
                         OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7, OP_SLT = 4'd8, OP_SLTU = 4'd9;

  typedef struct packed {
    logic [3:0]  cls;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  err;
  } rsp_t;

  req_t                  req;
  rsp_t                  rsp_q;
  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] addr_ptr;
  logic                  accept, xfer;
  logic [2:0]            f3_alu;
  logic [6:0]            f7_alu;
  logic                  is_shift;
  logic [31:0]           enc;
  logic                  fld_err, imm_bad;
  logic                  fit12, fit13, fit21;

  assign req = '{cls: bus.in_class, op: bus.in_alu_op, f3: bus.in_funct3, rd: bus.in_rd,
                 rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};

  assign bus.in_ready  = !clear && (!vld_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign xfer          = vld_q && bus.out_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_instr = rsp_q.instr;
  assign bus.out_addr  = rsp_q.addr;
  assign bus.out_err   = rsp_q.err;

  // Signed-range tests: all bits above the sign bit must replicate it.
  assign fit12 = (&req.imm[31:11]) | ~(|req.imm[31:11]);
  assign fit13 = (&req.imm[31:12]) | ~(|req.imm[31:12]);
  assign fit21 = (&req.imm[31:20]) | ~(|req.imm[31:20]);

  always_comb begin
    case (req.op)
      OP_AND:  f3_alu = 3'b111;
      OP_OR:   f3_alu = 3'b110;
      OP_XOR:  f3_alu = 3'b100;
      OP_SLL:  f3_alu = 3'b001;
      OP_SRL:  f3_alu = 3'b101;
      OP_SRA:  f3_alu = 3'b101;
      OP_SLT:  f3_alu = 3'b010;
      OP_SLTU: f3_alu = 3'b011;
      default: f3_alu = 3'b000;
    endcase
    f7_alu   = (req.op == OP_SUB || req.op == OP_SRA) ? 7'h20 : 7'h00;
    is_shift = (req.op == OP_SLL) || (req.op == OP_SRL) || (req.op == OP_SRA);
  end

  always_comb begin
    enc     = '0;
    fld_err = (req.op > OP_SLTU);
    imm_bad = 1'b0;
    case (req.cls)
      C_R: enc = {f7_alu, req.rs2, req.rs1, f3_alu, req.rd, 7'h33};
      C_IALU: begin
        if (req.op == OP_SUB) fld_err = 1'b1;
        if (is_shift) begin
          enc     = {f7_alu, req.imm[4:0], req.rs1, f3_alu, req.rd, 7'h13};
          imm_bad = |req.imm[31:5];
        end else begin
          enc     = {req.imm[11:0], req.rs1, f3_alu, req.rd, 7'h13};
          imm_bad = !fit12;
        end
      end
      C_LOAD: begin
        if (req.op != OP_ADD) fld_err = 1'b1;
        if (req.f3 == 3'b011 || req.f3 == 3'b110 || req.f3 == 3'b111) fld_err = 1'b1;
        enc     = {req.imm[11:0], req.rs1, req.f3, req.rd, 7'h03};
        imm_bad = !fit12;
      end
      C_STORE: begin
        if (req.op != OP_ADD) fld_err = 1'b1;
        if (req.f3 > 3'b010) fld_err = 1'b1;
        enc     = {req.imm[11:5], req.rs2, req.rs1, req.f3, req.imm[4:0], 7'h23};
        imm_bad = !fit12;
      end
      C_BRANCH: begin
        if (req.f3 == 3'b010 || req.f3 == 3'b011) fld_err = 1'b1;
        enc     = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.f3,
                   req.imm[4:1], req.imm[11], 7'h63};
        imm_bad = !fit13 || req.imm[0];
      end
      C_JAL: begin
        enc     = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, 7'h6F};
        imm_bad = !fit21 || req.imm[0];
      end
      C_JALR: begin
        enc     = {req.imm[11:0], req.rs1, 3'b000, req.rd, 7'h67};
        imm_bad = !fit12;
      end
      C_LUI: begin
        enc     = {req.imm[31:12], req.rd, 7'h37};
        imm_bad = |req.imm[11:0];
      end
      C_AUIPC: begin
        enc     = {req.imm[31:12], req.rd, 7'h17};
        imm_bad = |req.imm[11:0];
      end
      default: fld_err = 1'b1;
    endcase
  end

  // clear outranks accept/transfer: a pending word is dropped uncounted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= 1'b0;
      rsp_q       <= '{instr: '0, addr: BASE_ADDR, err: 1'b0};
      addr_ptr    <= BASE_ADDR;
      instr_count <= '0;
    end else if (clear) begin
      vld_q       <= 1'b0;
      addr_ptr    <= BASE_ADDR;
      instr_count <= '0;
    end else begin
      if (xfer && !(&instr_count)) instr_count <= instr_count + 1'b1;
      if (accept) begin
        vld_q    <= 1'b1;
        rsp_q    <= '{instr: enc, addr: addr_ptr, err: fld_err | (IMM_CHK & imm_bad)};
        addr_ptr <= addr_ptr + ADDR_WIDTH'(4);
      end else if (xfer) begin
        vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued on accept, checked on each output transfer.
module tb_instr_encoder;
`ifdef IMM_CHECK_EN
  localparam bit IMM_ERR = 1'b1;
`else
  localparam bit IMM_ERR = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    bit          chk_instr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [3:0] cnt;
  exp_t       sb[$];
  logic [31:0] exp_addr;
  int         vectors = 0;
  int         miscompares = 0;

  instr_encoder_if #(.ADDR_WIDTH(32)) bus ();

  instr_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus.slave), .instr_count(cnt)
  );

  always #5 clk = ~clk;

  // Transfer happens at the next rising edge; compare against the oldest queued word.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !clear) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got instr=%h addr=%h, expected none", bus.out_instr, bus.out_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ((e.chk_instr && bus.out_instr !== e.instr) || bus.out_addr !== e.addr || bus.out_err !== e.err) begin
          miscompares++;
          $display("FAIL %s: got instr=%h addr=%h err=%b, expected instr=%h addr=%h err=%b",
                   e.name, bus.out_instr, bus.out_addr, bus.out_err, e.instr, e.addr, e.err);
        end
      end
    end
  end

  task automatic send(input string nm, input logic [3:0] c, input logic [3:0] op, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] ei, input logic ee, input bit chk, output int waits);
    bit acc;
    bus.in_valid = 1'b1; bus.in_class = c; bus.in_alu_op = op; bus.in_funct3 = f3;
    bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    acc = 1'b0; waits = 0;
    while (!acc && waits < 50) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    if (acc) begin
      sb.push_back('{nm, ei, exp_addr, ee, chk});
      exp_addr += 32'd4;
    end else begin
      vectors++; miscompares++;
      $display("FAIL %s_accept: in_ready never seen within %0d cycles, expected acceptance", nm, waits);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    sb.delete();
    exp_addr = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_addr !== 32'h0 ||
        bus.out_err !== 1'b0 || cnt !== 4'h0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b instr=%h addr=%h err=%b cnt=%0d rdy=%b, expected 0/0/0/0/0/1",
               bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, cnt, bus.in_ready);
    end
  endtask

  task automatic test_addi();
    int w;
    bus.out_ready = 1'b1;
    // rs2 is irrelevant for I-type and must not leak into the word
    send("addi", 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd31, 32'd5, 32'h00500093, 1'b0, 1'b1, w);
    idle();
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL addi_latency: out_valid=%b one cycle after accept, expected 1", bus.out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL addi_drain: valid=%b cnt=%0d, expected 0/1", bus.out_valid, cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w0, w1;
    do_clear();
    bus.out_ready = 1'b1;
    send("add", 4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0, 1'b1, w0);
    send("sub", 4'd0, 4'd1, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1'b0, 1'b1, w1);
    idle();
    vectors++;
    if (w1 !== 0) begin
      miscompares++;
      $display("FAIL b2b_bubble: second word waited %0d cycles, expected 0", w1);
    end
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (cnt !== 4'd2) begin
      miscompares++;
      $display("FAIL b2b_count: cnt=%0d, expected 2", cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int w;
    do_clear();
    bus.out_ready = 1'b0;
    send("stall_a", 4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0, 1'b1, w);
    bus.in_alu_op = 4'd1;  // next word offered while the first is stuck
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_instr !== 32'h002081B3 || cnt !== 4'd0) begin
        miscompares++;
        $display("FAIL stall_hold: rdy=%b valid=%b instr=%h cnt=%0d, expected 0/1/002081b3/0",
                 bus.in_ready, bus.out_valid, bus.out_instr, cnt);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send("stall_b", 4'd0, 4'd1, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1'b0, 1'b1, w);
    idle();
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (cnt !== 4'd2) begin
      miscompares++;
      $display("FAIL stall_count: cnt=%0d, expected 2", cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    int w;
    do_clear();
    bus.out_ready = 1'b0;
    send("clr_dropped", 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 1'b1, w);
    bus.in_class = 4'd4; bus.in_funct3 = 3'd0; bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2; bus.in_imm = 32'd8;
    clear = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_ready: in_ready=%b during clear, expected 0", bus.in_ready);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    idle();
    sb.delete();
    exp_addr = 32'h0;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL clear_state: valid=%b cnt=%0d, expected 0/0", bus.out_valid, cnt);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send("clr_beq", 4'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463, 1'b0, 1'b1, w);
    idle();
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL clear_count: cnt=%0d, expected 1", cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_encodings();
    int w;
    do_clear();
    bus.out_ready = 1'b1;
    send("jal",   4'd5, 4'd0, 3'd0, 5'd1,  5'd0, 5'd0, 32'd16,        32'h010000EF, 1'b0, 1'b1, w);
    send("lui",   4'd7, 4'd0, 3'd0, 5'd5,  5'd0, 5'd0, 32'h12345000,  32'h123452B7, 1'b0, 1'b1, w);
    send("sw",    4'd3, 4'd0, 3'd2, 5'd0,  5'd1, 5'd2, 32'd8,         32'h0020A423, 1'b0, 1'b1, w);
    send("lw",    4'd2, 4'd0, 3'd2, 5'd5,  5'd2, 5'd0, 32'hFFFFFFFC,  32'hFFC12283, 1'b0, 1'b1, w);
    send("srai",  4'd1, 4'd7, 3'd0, 5'd3,  5'd1, 5'd0, 32'd4,         32'h4040D193, 1'b0, 1'b1, w);
    send("jalr",  4'd6, 4'd0, 3'd5, 5'd0,  5'd1, 5'd0, 32'd0,         32'h00008067, 1'b0, 1'b1, w);
    send("auipc", 4'd8, 4'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h00001000,  32'h00001517, 1'b0, 1'b1, w);
    send("sltu",  4'd0, 4'd9, 3'd0, 5'd4,  5'd5, 5'd6, 32'h0,         32'h0062B233, 1'b0, 1'b1, w);
    send("bne",   4'd4, 4'd0, 3'd1, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFC,  32'hFE209EE3, 1'b0, 1'b1, w);
    send("addi_m1", 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, 1'b1, w);
    idle();
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_errors();
    int w;
    do_clear();
    bus.out_ready = 1'b1;
    send("br_f3_010",  4'd4,  4'd0,  3'd2, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A463, 1'b1, 1'b1, w);
    send("ld_f3_011",  4'd2,  4'd0,  3'd3, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFFC13283, 1'b1, 1'b1, w);
    send("ld_op_sub",  4'd2,  4'd1,  3'd2, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFFC12283, 1'b1, 1'b1, w);
    send("st_f3_011",  4'd3,  4'd0,  3'd3, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020B423, 1'b1, 1'b1, w);
    send("ialu_sub",   4'd1,  4'd1,  3'd0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h0,        1'b1, 1'b0, w);
    send("class_9",    4'd9,  4'd0,  3'd0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h0,        1'b1, 1'b0, w);
    send("aluop_10",   4'd0,  4'd10, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0,        32'h0,        1'b1, 1'b0, w);
    send("addi_2048",  4'd1,  4'd0,  3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093, IMM_ERR, 1'b1, w);
    send("lui_lowbits",4'd7,  4'd0,  3'd0, 5'd5, 5'd0, 5'd0, 32'h12345678, 32'h123452B7, IMM_ERR, 1'b1, w);
    send("jal_odd",    4'd5,  4'd0,  3'd0, 5'd1, 5'd0, 5'd0, 32'd17,       32'h010000EF, IMM_ERR, 1'b1, w);
    idle();
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int w;
    do_clear();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      send("sat_addi", 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'(i),
           {12'(i), 5'd0, 3'd0, 5'd1, 7'h13}, 1'b0, 1'b1, w);
    idle();
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (cnt !== 4'hF) begin
      miscompares++;
      $display("FAIL count_saturate: cnt=%0d, expected 15", cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int w;
    bus.out_ready = 1'b0;
    send("rst_dropped", 4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0, 1'b1, w);
    idle();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_addr !== 32'h0 || cnt !== 4'h0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b instr=%h addr=%h cnt=%0d, expected all 0",
               bus.out_valid, bus.out_instr, bus.out_addr, cnt);
    end
    sb.delete();
    exp_addr = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send("post_rst", 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 1'b1, w);
    idle();
    repeat (3) @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; exp_addr = 32'h0;
    bus.in_valid = 1'b0; bus.in_class = '0; bus.in_alu_op = '0; bus.in_funct3 = '0;
    bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.out_ready = 1'b0;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_addi();
    test_back_to_back();
    test_stall();
    test_clear();
    test_encodings();
    test_errors();
    test_saturation();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d words outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
